// File: rtl/core_packet_ingress_if.sv
// Core-to-router flit bus: 4-phase bundled-data input side, valid/ready output side
// and status. The ingress block is the slave; the core/router side is the master.
interface core_packet_ingress_if #(
    parameter int unsigned DATA_W = 11
);
    logic              in_req;
    logic [DATA_W-1:0] in_data;
    logic [1:0]        in_ctrl;
    logic              in_ack;
    logic              out_valid;
    logic [DATA_W+1:0] out_data;
    logic              out_ready;
    logic [7:0]        pkt_count;
    logic              seq_err;

    modport master (
        output in_req, in_data, in_ctrl, out_ready,
        input  in_ack, out_valid, out_data, pkt_count, seq_err
    );

    modport slave (
        input  in_req, in_data, in_ctrl, out_ready,
        output in_ack, out_valid, out_data, pkt_count, seq_err
    );
endinterface

// File: rtl/core_packet_ingress.sv
// Ingress from an asynchronous 4-phase core port into a DEPTH-entry flit FIFO,
// with packet-sequence checking and a completed-packet counter.
module core_packet_ingress #(
    parameter int unsigned DATA_W      = 11,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    core_packet_ingress_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW-1:0] PTR_ONE  = 1;

    typedef enum logic {IDLE, ACKED} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [DATA_W+1:0]      mem_q [DEPTH];
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]            count_q, count_d;
    logic                   in_pkt_q, in_pkt_d;
    logic                   seq_err_q, seq_err_d;
    logic [7:0]             pkt_count_q, pkt_count_d;

    logic req_s, full, push, pop, ack;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], bus.in_req};
    assign req_s  = sync_q[SYNC_STAGES-1];
    assign full   = (count_q == FULL_CNT);
    assign pop    = (count_q != '0) && bus.out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (req_s && !full) state_d = ACKED;
            ACKED: if (!req_s)         state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ack  = (state_q == ACKED);
        push = (state_q == IDLE) && req_s && !full;
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop)      count_d = count_q + CNT_ONE;
        else if (pop && !push) count_d = count_q - CNT_ONE;
    end

    // Tracker advances on every push, even for out-of-sequence flits.
    always_comb begin
        in_pkt_d    = in_pkt_q;
        seq_err_d   = seq_err_q;
        pkt_count_d = pkt_count_q;
        if (push) begin
            unique case (bus.in_ctrl)
                2'b01: begin
                    if (in_pkt_q) seq_err_d = 1'b1;
                    in_pkt_d = 1'b1;
                end
                2'b10: begin
                    if (!in_pkt_q) seq_err_d = 1'b1;
                    in_pkt_d = 1'b0;
                end
                2'b11: begin
                    if (in_pkt_q) seq_err_d = 1'b1;
                    in_pkt_d = 1'b0;
                end
                default: begin
                    if (!in_pkt_q) seq_err_d = 1'b1;
                end
            endcase
            if (bus.in_ctrl[1]) pkt_count_d = pkt_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            in_pkt_q    <= 1'b0;
            seq_err_q   <= 1'b0;
            pkt_count_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            sync_q      <= sync_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            in_pkt_q    <= in_pkt_d;
            seq_err_q   <= seq_err_d;
            pkt_count_q <= pkt_count_d;
            if (push) mem_q[wr_ptr_q] <= {bus.in_ctrl, bus.in_data};
        end
    end

    assign bus.in_ack    = ack;
    assign bus.out_valid = (count_q != '0);
    assign bus.out_data  = mem_q[rd_ptr_q];
    assign bus.pkt_count = pkt_count_q;
    assign bus.seq_err   = seq_err_q;
endmodule

// File: tb/tb_core_packet_ingress.sv
// Directed bench for core_packet_ingress: handshake latency, ordering, full-FIFO
// backpressure, sequence errors and mid-handshake reset.
module tb_core_packet_ingress;
    logic clk = 1'b0;
    logic reset;
    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    logic [12:0] popq [$];

    core_packet_ingress_if #(.DATA_W(11)) bus ();

    core_packet_ingress #(.DATA_W(11), .DEPTH(4), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset && bus.out_valid && bus.out_ready) popq.push_back(bus.out_data);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ack(input logic lvl, input string tag);
        int unsigned n = 0;
        while (bus.in_ack !== lvl && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'd0, bus.in_ack}, {31'd0, lvl});
    endtask

    task automatic hs(input logic [1:0] ctrl, input logic [10:0] data);
        bus.in_ctrl = ctrl;
        bus.in_data = data;
        bus.in_req  = 1'b1;
        @(negedge clk);
        wait_ack(1'b1, "hs_ack_rise");
        bus.in_req = 1'b0;
        wait_ack(1'b0, "hs_ack_fall");
    endtask

    initial begin
        reset         = 1'b1;
        bus.in_req    = 1'b0;
        bus.in_data   = '0;
        bus.in_ctrl   = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ack",   bus.in_ack, 0);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_data",  bus.out_data, 0);
        chk("rst_pkt",   bus.pkt_count, 0);
        chk("rst_err",   bus.seq_err, 0);
        reset = 1'b0;
        @(negedge clk);

        // Single flit with exact handshake latency
        bus.in_ctrl = 2'b11;
        bus.in_data = 11'h5A3;
        bus.in_req  = 1'b1;
        @(negedge clk); chk("lat_e1", bus.in_ack, 0);
        @(negedge clk); chk("lat_e2", bus.in_ack, 0);
        @(negedge clk); chk("lat_e3", bus.in_ack, 1);
        chk("single_valid", bus.out_valid, 1);
        chk("single_data",  bus.out_data, 13'h1DA3);
        chk("single_pkt",   bus.pkt_count, 1);
        chk("single_err",   bus.seq_err, 0);
        bus.in_req = 1'b0;
        @(negedge clk); chk("fall_e1", bus.in_ack, 1);
        @(negedge clk); chk("fall_e2", bus.in_ack, 1);
        @(negedge clk); chk("fall_e3", bus.in_ack, 0);
        bus.out_ready = 1'b1;
        @(negedge clk); chk("single_popped", bus.out_valid, 0);
        popq.delete();

        // Head/body/tail packet streamed straight through
        hs(2'b01, 11'h001);
        hs(2'b00, 11'h002);
        hs(2'b10, 11'h003);
        repeat (2) @(negedge clk);
        chk("pkt_n",    popq.size(), 3);
        chk("pkt_head", popq[0], 13'h0801);
        chk("pkt_body", popq[1], 13'h0002);
        chk("pkt_tail", popq[2], 13'h1003);
        chk("pkt_cnt",  bus.pkt_count, 2);
        chk("pkt_err",  bus.seq_err, 0);
        popq.delete();

        // Fill the FIFO, then stall a fifth handshake
        bus.out_ready = 1'b0;
        hs(2'b11, 11'h010);
        hs(2'b11, 11'h011);
        hs(2'b11, 11'h012);
        hs(2'b11, 11'h013);
        chk("full_cnt",  dut.count_q, 4);
        chk("full_head", bus.out_data, 13'h1810);
        bus.in_ctrl = 2'b11;
        bus.in_data = 11'h014;
        bus.in_req  = 1'b1;
        repeat (6) @(negedge clk);
        chk("stall_ack", bus.in_ack, 0);
        chk("stall_cnt", dut.count_q, 4);
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("popfull_cnt", dut.count_q, 3);
        chk("popfull_ack", bus.in_ack, 0);
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("refill_cnt", dut.count_q, 4);
        chk("refill_ack", bus.in_ack, 1);
        bus.in_req = 1'b0;
        wait_ack(1'b0, "stall_ack_fall");
        bus.out_ready = 1'b1;
        repeat (6) @(negedge clk);
        chk("drain_n",     popq.size(), 5);
        chk("drain_first", popq[0], 13'h1810);
        chk("drain_last",  popq[4], 13'h1814);
        chk("drain_valid", bus.out_valid, 0);
        chk("drain_pkt",   bus.pkt_count, 7);
        popq.delete();

        // Orphan body flit raises a sticky error
        hs(2'b00, 11'h055);
        chk("orphan_err", bus.seq_err, 1);
        hs(2'b11, 11'h066);
        repeat (3) @(negedge clk);
        chk("sticky_err",  bus.seq_err, 1);
        chk("orphan_pkt",  bus.pkt_count, 8);
        chk("orphan_n",    popq.size(), 2);
        chk("orphan_body", popq[0], 13'h0055);
        chk("orphan_sgl",  popq[1], 13'h1866);
        popq.delete();

        // Reset while acknowledged with two entries queued
        bus.out_ready = 1'b0;
        hs(2'b11, 11'h0A1);
        bus.in_ctrl = 2'b11;
        bus.in_data = 11'h0A2;
        bus.in_req  = 1'b1;
        @(negedge clk);
        wait_ack(1'b1, "mid_ack");
        chk("mid_cnt", dut.count_q, 2);
        chk("mid_pkt", bus.pkt_count, 10);
        reset = 1'b1;
        #1;
        chk("arst_ack",   bus.in_ack, 0);
        chk("arst_valid", bus.out_valid, 0);
        chk("arst_pkt",   bus.pkt_count, 0);
        chk("arst_err",   bus.seq_err, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rel_nopush", bus.out_valid, 0);
        wait_ack(1'b1, "recap_ack");
        chk("recap_data",  bus.out_data, 13'h18A2);
        chk("recap_valid", bus.out_valid, 1);
        chk("recap_pkt",   bus.pkt_count, 1);
        chk("recap_err",   bus.seq_err, 0);
        bus.in_req = 1'b0;
        wait_ack(1'b0, "recap_fall");
        chk("recap_cnt", dut.count_q, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
